// File: rtl/instr_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_if
// Purpose  : Bundles the instruction fetch unit's control-unit handshake and
//            instruction-memory bus into one interface.
// Ports    : start, pc_load, pc_in       - fetch request / pc load from control
//            mem_addr, mem_rd            - byte read request to instruction memory
//            mem_rdata, mem_ready        - byte returned by instruction memory
//            pc, instr, instr_valid,
//            busy, fetch_err             - status and result to control / decode
// Modports : slave  - the fetch unit itself
//            master - the environment (control unit + memory) driving it
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_in;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              busy;
  logic              fetch_err;

  modport master (
    output start, pc_load, pc_in, mem_rdata, mem_ready,
    input  mem_addr, mem_rd, pc, instr, instr_valid, busy, fetch_err
  );

  modport slave (
    input  start, pc_load, pc_in, mem_rdata, mem_ready,
    output mem_addr, mem_rd, pc, instr, instr_valid, busy, fetch_err
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Multicycle instruction fetch for the 8-bit MIPS datapath. Reads
//            four consecutive bytes (little-endian) from the 8-bit instruction
//            memory, assembles a 32-bit instruction and maintains the pc.
// Ports    : clk   - clock, rising edge
//            reset - synchronous, active-high
//            bus   - instr_fetch_if.slave (control handshake + memory bus)
// Options  : FETCH_TIMEOUT_EN - when defined, a READ that sees TIMEOUT_CYCLES
//            consecutive not-ready cycles aborts, restores pc to the fetch
//            start address and pulses fetch_err. Undefined: READ waits forever
//            and fetch_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int ADDR_W = 8
`ifdef FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [31:0]       instr_q, instr_d;

  // Address a fetch starts from: a pc_load in the same cycle as start wins.
  logic [ADDR_W-1:0] fetch_pc;
  assign fetch_pc = bus.pc_load ? bus.pc_in : pc_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] start_pc_q, start_pc_d;
  logic              err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bcnt_d  = bcnt_q;
    instr_d = instr_q;
`ifdef FETCH_TIMEOUT_EN
    wait_d     = wait_q;
    start_pc_d = start_pc_q;
    err_d      = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        pc_d = fetch_pc;
        if (bus.start) begin
          state_d = S_READ;
          bcnt_d  = 2'd0;
`ifdef FETCH_TIMEOUT_EN
          wait_d     = '0;
          start_pc_d = fetch_pc;
`endif
        end
      end
      S_READ: begin
        if (bus.mem_ready) begin
          instr_d[{bcnt_q, 3'b000} +: 8] = bus.mem_rdata;
          pc_d   = pc_q + ADDR_W'(1);
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            state_d = S_DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          wait_d = '0;
        end else if (wait_q == WAIT_LAST) begin
          // Give up: rewind pc so the control unit can retry the same fetch;
          // instr keeps whatever bytes were already captured.
          state_d = S_IDLE;
          pc_d    = start_pc_q;
          bcnt_d  = 2'd0;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      bcnt_q  <= 2'd0;
      instr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bcnt_q  <= bcnt_d;
      instr_q <= instr_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q     <= '0;
      start_pc_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      start_pc_q <= start_pc_d;
      err_q      <= err_d;
    end
  end

  assign bus.fetch_err = err_q;
`else
  assign bus.fetch_err = 1'b0;
`endif

  // Every output is a register or a decode of the state register.
  assign bus.mem_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.mem_rd      = (state_q == S_READ);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.instr_valid = (state_q == S_DONE);
  assign bus.instr       = instr_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch. A byte-array memory and a
//            transaction-level model (start address, per-byte stall plan)
//            predict the per-cycle bus trace, the assembled instruction and
//            the final pc of every fetch.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();
  instr_fetch #(.ADDR_W(ADDR_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mem [256];
  int          stall_plan [4];
  bit          poke_ctl;
  logic [11:0] obs_tr [$];
  logic [11:0] exp_tr [$];
  logic [31:0] obs_instr_done, obs_instr_first, exp_instr, exp_first;
  logic [7:0]  obs_pc, exp_pc;
  logic [7:0]  model_pc;
  logic [31:0] model_instr;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {fetch_err, instr_valid, busy, mem_rd, mem_addr}
  function automatic logic [11:0] sample();
    return {bus.fetch_err, bus.instr_valid, bus.busy, bus.mem_rd, bus.mem_addr};
  endfunction

  task automatic poke();
    if (poke_ctl) begin
      bus.start   = 1'b1;
      bus.pc_load = 1'b1;
      bus.pc_in   = 8'h40;
    end
  endtask

  // Runs one whole fetch from IDLE (caller is #1 after an edge) and records
  // what the DUT shows; also builds the expected trace from the stall plan.
  task automatic run_fetch(input logic [7:0] addr, input bit load);
    logic [7:0] a0;
    a0 = load ? addr : model_pc;
    obs_tr.delete();
    exp_tr.delete();
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < stall_plan[b]; s++) exp_tr.push_back({4'b0011, 8'(a0 + b)});
      exp_tr.push_back({4'b0011, 8'(a0 + b)});
    end
    exp_tr.push_back({4'b0110, 8'(a0 + 4)});
    exp_tr.push_back({4'b0000, 8'(a0 + 4)});
    exp_instr = {mem[8'(a0 + 3)], mem[8'(a0 + 2)], mem[8'(a0 + 1)], mem[a0]};
    exp_pc    = 8'(a0 + 4);
    exp_first = model_instr;

    bus.pc_in   = addr;
    bus.pc_load = load;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
    bus.pc_load = 1'b0;
    bus.pc_in   = 8'($urandom);
    obs_instr_first = bus.instr;
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < stall_plan[b]; s++) begin
        obs_tr.push_back(sample());
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 8'($urandom);
        poke();
        step();
      end
      obs_tr.push_back(sample());
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem[bus.mem_addr];
      poke();
      step();
    end
    obs_tr.push_back(sample());
    obs_instr_done = bus.instr;
    bus.mem_ready  = 1'b0;
    poke();
    step();
    bus.start   = 1'b0;
    bus.pc_load = 1'b0;
    obs_tr.push_back(sample());
    obs_pc = bus.pc;
    model_pc    = exp_pc;
    model_instr = exp_instr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_cmp++;
    if (sample() !== 12'h000 || bus.pc !== 8'h00 || bus.instr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: got trace=%h pc=%h instr=%h want 000/00/00000000", sample(), bus.pc, bus.instr);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (sample() !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_idle: got %h want 000", sample());
    end
    model_pc = 8'h00;
    model_instr = 32'h0;
  endtask

  task automatic test_pc_load();
    bus.pc_load = 1'b1;
    bus.pc_in   = 8'h10;
    step();
    bus.pc_load = 1'b0;
    n_cmp++;
    if (bus.pc !== 8'h10 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pc_load: got pc=%h busy=%b want pc=10 busy=0", bus.pc, bus.busy);
    end
    model_pc = 8'h10;
  endtask

  task automatic test_basic();
    mem[8'h10] = 8'hEF; mem[8'h11] = 8'hBE; mem[8'h12] = 8'hAD; mem[8'h13] = 8'hDE;
    stall_plan = '{0, 0, 0, 0};
    run_fetch(8'h00, 1'b0);
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_cmp++;
      if (obs_tr[i] !== exp_tr[i]) begin
        n_bad++;
        $display("FAIL basic_trace cycle %0d: got %h want %h", i + 1, obs_tr[i], exp_tr[i]);
      end
    end
    n_cmp++;
    if (obs_instr_done !== 32'hDEADBEEF || obs_pc !== 8'h14) begin
      n_bad++;
      $display("FAIL basic_result: got instr=%h pc=%h want DEADBEEF/14", obs_instr_done, obs_pc);
    end
  endtask

  task automatic test_stall();
    stall_plan = '{0, 0, 3, 0};
    run_fetch(8'h10, 1'b1);
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_cmp++;
      if (obs_tr[i] !== exp_tr[i]) begin
        n_bad++;
        $display("FAIL stall_trace cycle %0d: got %h want %h", i + 1, obs_tr[i], exp_tr[i]);
      end
    end
    n_cmp++;
    if (obs_instr_done !== 32'hDEADBEEF || obs_pc !== 8'h14) begin
      n_bad++;
      $display("FAIL stall_result: got instr=%h pc=%h want DEADBEEF/14", obs_instr_done, obs_pc);
    end
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03; mem[8'h01] = 8'h04;
    stall_plan = '{0, 1, 0, 0};
    run_fetch(8'hFE, 1'b1);
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_cmp++;
      if (obs_tr[i] !== exp_tr[i]) begin
        n_bad++;
        $display("FAIL wrap_trace cycle %0d: got %h want %h", i + 1, obs_tr[i], exp_tr[i]);
      end
    end
    n_cmp++;
    if (obs_instr_done !== 32'h04030201 || obs_pc !== 8'h02) begin
      n_bad++;
      $display("FAIL wrap_result: got instr=%h pc=%h want 04030201/02", obs_instr_done, obs_pc);
    end
  endtask

  task automatic test_ignore_ctl();
    poke_ctl   = 1'b1;
    stall_plan = '{1, 2, 0, 1};
    run_fetch(8'h80, 1'b1);
    poke_ctl   = 1'b0;
    for (int i = 0; i < exp_tr.size(); i++) begin
      n_cmp++;
      if (obs_tr[i] !== exp_tr[i]) begin
        n_bad++;
        $display("FAIL ignore_trace cycle %0d: got %h want %h", i + 1, obs_tr[i], exp_tr[i]);
      end
    end
    n_cmp++;
    if (obs_instr_done !== exp_instr || obs_pc !== 8'h84) begin
      n_bad++;
      $display("FAIL ignore_result: got instr=%h pc=%h want %h/84", obs_instr_done, obs_pc, exp_instr);
    end
  endtask

  // Back-to-back random fetches: each new start lands on the IDLE cycle.
  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      foreach (stall_plan[k]) stall_plan[k] = int'($urandom_range(0, 3));
      poke_ctl = 1'($urandom_range(0, 1));
      run_fetch(8'($urandom), 1'($urandom_range(0, 1)));
      poke_ctl = 1'b0;
      for (int i = 0; i < exp_tr.size(); i++) begin
        n_cmp++;
        if (obs_tr[i] !== exp_tr[i]) begin
          n_bad++;
          $display("FAIL random%0d_trace cycle %0d: got %h want %h", t, i + 1, obs_tr[i], exp_tr[i]);
        end
      end
      n_cmp++;
      if (obs_instr_done !== exp_instr || obs_pc !== exp_pc || obs_instr_first !== exp_first) begin
        n_bad++;
        $display("FAIL random%0d_result: got instr=%h pc=%h held=%h want %h/%h/%h",
                 t, obs_instr_done, obs_pc, obs_instr_first, exp_instr, exp_pc, exp_first);
      end
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_long_stall();
    logic [31:0] partial;
    partial = {model_instr[31:8], mem[8'h20]};
    bus.pc_load = 1'b1;
    bus.pc_in   = 8'h20;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    bus.pc_load = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = mem[bus.mem_addr];
    step();
    for (int s = 0; s < 16; s++) begin
      n_cmp++;
      if (sample() !== {4'b0011, 8'h21}) begin
        n_bad++;
        $display("FAIL timeout_wait stall %0d: got %h want 321", s, sample());
      end
      bus.mem_ready = 1'b0;
      step();
    end
    n_cmp++;
    if (sample() !== {4'b1000, 8'h20} || bus.instr !== partial) begin
      n_bad++;
      $display("FAIL timeout_abort: got trace=%h instr=%h want 820/%h", sample(), bus.instr, partial);
    end
    step();
    n_cmp++;
    if (sample() !== {4'b0000, 8'h20}) begin
      n_bad++;
      $display("FAIL timeout_after: got %h want 020", sample());
    end
    model_pc = 8'h20;
    model_instr = partial;
  endtask
`else
  task automatic test_long_stall();
    bus.pc_load = 1'b1;
    bus.pc_in   = 8'h50;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    bus.pc_load = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = mem[bus.mem_addr];
    step();
    for (int s = 0; s < 40; s++) begin
      n_cmp++;
      if (sample() !== {4'b0011, 8'h51}) begin
        n_bad++;
        $display("FAIL long_stall stall %0d: got %h want 351", s, sample());
      end
      bus.mem_ready = 1'b0;
      step();
    end
    for (int b = 0; b < 3; b++) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem[bus.mem_addr];
      step();
    end
    bus.mem_ready = 1'b0;
    exp_instr = {mem[8'h53], mem[8'h52], mem[8'h51], mem[8'h50]};
    n_cmp++;
    if (sample() !== {4'b0110, 8'h54} || bus.instr !== exp_instr) begin
      n_bad++;
      $display("FAIL long_stall_done: got trace=%h instr=%h want 654/%h", sample(), bus.instr, exp_instr);
    end
    step();
    model_pc = 8'h54;
    model_instr = exp_instr;
  endtask
`endif

  task automatic test_reset_mid();
    bus.pc_load = 1'b1;
    bus.pc_in   = 8'h30;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    bus.pc_load = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.mem_ready = 1'b1;
      bus.mem_rdata = mem[bus.mem_addr];
      step();
    end
    reset = 1'b1;
    bus.mem_rdata = mem[bus.mem_addr];
    step();
    reset = 1'b0;
    bus.mem_ready = 1'b0;
    n_cmp++;
    if (sample() !== 12'h000 || bus.pc !== 8'h00 || bus.instr !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_mid: got trace=%h pc=%h instr=%h want 000/00/00000000", sample(), bus.pc, bus.instr);
    end
    for (int c = 0; c < 6; c++) begin
      bus.mem_ready = 1'b1;
      step();
      n_cmp++;
      if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_mid_quiet cycle %0d: got valid=%b busy=%b want 0/0", c, bus.instr_valid, bus.busy);
      end
    end
    bus.mem_ready = 1'b0;
    model_pc = 8'h00;
    model_instr = 32'h0;
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.pc_load   = 1'b0;
    bus.pc_in     = '0;
    bus.mem_rdata = 8'h00;
    bus.mem_ready = 1'b0;
    poke_ctl      = 1'b0;
    reset         = 1'b1;
    foreach (mem[i]) mem[i] = 8'($urandom);
    test_reset();
    test_pc_load();
    test_basic();
    test_stall();
    test_wrap();
    test_ignore_ctl();
    test_random();
    test_long_stall();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Multicycle instruction fetch unit for the 8-bit MIPS datapath. On a start request from the control unit it reads four consecutive bytes from the 8-bit instruction memory and assembles them into one 32-bit instruction word. It maintains the program counter and signals completion to the control unit. It sits between instruction memory (upstream) and the control unit / decode (downstream).

## Interface
- ADDR_W, 8, program counter and memory address width
- TIMEOUT_CYCLES, 16, consecutive not-ready cycles before a fetch aborts; used only with FETCH_TIMEOUT_EN
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  reset, synchronous, active-high
- start  in  1  fetch request from the control unit; sampled only in IDLE
- pc_load  in  1  load pc from pc_in; honoured only in IDLE
- pc_in  in  ADDR_W  branch/jump target
- mem_rdata  in  8  byte returned by instruction memory
- mem_ready  in  1  mem_rdata valid this cycle
- mem_addr  out  ADDR_W  byte address, equal to pc
- mem_rd  out  1  read strobe, high throughout READ
- pc  out  ADDR_W  current program counter
- instr  out  32  assembled instruction
- instr_valid  out  1  one-cycle pulse when instr is complete
- busy  out  1  high in READ and DONE
- fetch_err  out  1  one-cycle abort pulse (FETCH_TIMEOUT_EN only, else constant 0)

## Operation
- States:
  - IDLE: default state.
  - READ: byte collection.
  - DONE: completion cycle.
- IDLE:
  - pc_load=1 → pc <= pc_in.
  - start=1 → READ, byte counter bcnt <= 0, start_pc <= the pc value used for the fetch.
  - pc_load and start in the same cycle → pc <= pc_in, and the fetch begins at pc_in.
- READ:
  - mem_rd=1 and mem_addr=pc.
  - Each cycle with mem_ready=1: instr[8*bcnt+7 : 8*bcnt] <= mem_rdata (little-endian), pc <= pc+1 (mod 2^ADDR_W), bcnt <= bcnt+1.
  - After the capture with bcnt=3 → DONE.
  - mem_ready=0 → hold all state.
- DONE: instr_valid=1 for exactly one cycle, then IDLE.
- instr is held stable from DONE until the first byte capture of the next fetch.
- start and pc_load outside IDLE are ignored, with no queuing.
- pc wrap: a fetch at 8'hFE reads FE, FF, 00, 01 and ends with pc=8'h02.
- Reset, including mid-fetch:
  - state IDLE, pc=0, bcnt=0, instr=0.
  - instr_valid=0, busy=0, mem_rd=0, fetch_err=0.
  - Any partial instruction is discarded.

## Timing
- start high at cycle 0 in IDLE → READ at cycle 1.
- With mem_ready held high, bytes are captured at cycles 1–4 and instr_valid=1 at cycle 5. Best-case latency is 5 cycles, start to instr_valid.
- Each not-ready cycle adds one cycle of latency.
- IDLE is re-entered at cycle 6. The earliest next start is accepted at cycle 6, so back-to-back throughput is one instruction per 6 cycles.
- mem_rdata is sampled on the same edge that mem_ready is sampled high; the memory is combinational or ready-qualified.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - A wait counter counts consecutive READ cycles with mem_ready=0.
  - The counter clears on every capture and on entry to READ.
  - When the counter reaches TIMEOUT_CYCLES: → IDLE, pc <= start_pc, bcnt <= 0, fetch_err=1 for one cycle, instr_valid stays 0, instr keeps its partial content.
- FETCH_TIMEOUT_EN undefined:
  - READ waits indefinitely.
  - fetch_err is tied to 0.
  - No wait counter is synthesised.

## Test plan
- Reset, then pc_load=1 with pc_in=8'h10, then start; memory bytes 10:EF 11:BE 12:AD 13:DE, mem_ready always 1 → instr_valid at cycle 5, instr=32'hDEADBEEF, pc=8'h14.
- Same fetch with mem_ready low for 3 cycles before byte 2 → instr_valid at cycle 8, instr=32'hDEADBEEF, mem_addr held at 8'h12 during the stall.
- pc=8'hFE, bytes FE:01 FF:02 00:03 01:04 → instr=32'h04030201, pc=8'h02 (wrap).
- Reset asserted after 2 bytes captured → next cycle state IDLE, pc=0, instr=0, busy=0; no instr_valid pulse.
- start and pc_load (pc_in=8'h40) pulsed during READ → ignored; the fetch completes from its original address and pc ends at start address+4.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16, fetch from 8'h20, mem_ready held 0 after 1 byte → fetch_err pulse after 16 stall cycles, pc=8'h20, state IDLE, instr_valid never high.
